// File: rtl/fifo_uart_tx.sv
// Pops bytes from an attached syn_fifo and shifts each one out as a serial frame:
// one start bit (0), DATA_WIDTH data bits LSB first, one stop bit (1).
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  txEnable,
    input  logic                  fifoEmpty,
    input  logic [DATA_WIDTH-1:0] fifoRdData,
    output logic                  fifoRdEn,
    output logic                  txOut,
    output logic                  txBusy,
    output logic [CNT_WIDTH-1:0]  bytesSent
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, WAIT, START, DATA, STOP} stateT;

    stateT                 state;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [DATA_WIDTH-1:0] shiftNext;
    logic [BIT_W-1:0]      bitCnt;
    logic [BAUD_W-1:0]     baudCnt;
    logic                  baudLast;

    assign shiftNext = shiftReg >> 1;
    assign baudLast  = (baudCnt == BAUD_LAST);

    // Gated by reset so no pop can escape while the block is held in reset.
    assign fifoRdEn = reset && (state == IDLE) && txEnable && !fifoEmpty;
    assign txBusy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            txOut     <= 1'b1;
            shiftReg  <= '0;
            bitCnt    <= '0;
            baudCnt   <= '0;
            bytesSent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    txOut   <= 1'b1;
                    baudCnt <= '0;
                    bitCnt  <= '0;
                    if (fifoRdEn) state <= WAIT;
                end
                WAIT: begin
                    // Read data is valid now, one cycle after the pop strobe.
                    shiftReg <= fifoRdData;
                    txOut    <= 1'b0;
                    baudCnt  <= '0;
                    state    <= START;
                end
                START: begin
                    if (baudLast) begin
                        baudCnt <= '0;
                        bitCnt  <= '0;
                        txOut   <= shiftReg[0];
                        state   <= DATA;
                    end else begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baudLast) begin
                        baudCnt <= '0;
                        if (bitCnt == BIT_LAST) begin
                            txOut <= 1'b1;
                            state <= STOP;
                        end else begin
                            shiftReg <= shiftNext;
                            txOut    <= shiftNext[0];
                            bitCnt   <= bitCnt + BIT_W'(1);
                        end
                    end else begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baudLast) begin
                        baudCnt   <= '0;
                        bytesSent <= bytesSent + CNT_WIDTH'(1);
                        state     <= IDLE;
                    end else begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end
                end
                default: begin
                    txOut <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a queue models the FIFO, and every frame is
// checked cycle by cycle against hand-derived line levels.
module tb_fifo_uart_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        txEnable;
    logic        fifoEmpty;
    logic [7:0]  fifoRdData;
    logic        fifoRdEn, txOut, txBusy;
    logic [15:0] bytesSent;
    logic        fifoRdEnW, txOutW, txBusyW;
    logic [1:0]  bytesSentW;

    logic [7:0]  q[$];
    int          checkCount = 0;
    int          failCount  = 0;
    int          popCount   = 0;
    int          badPops    = 0;
    logic        lastPop    = 1'b0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .txEnable(txEnable), .fifoEmpty(fifoEmpty),
        .fifoRdData(fifoRdData), .fifoRdEn(fifoRdEn), .txOut(txOut),
        .txBusy(txBusy), .bytesSent(bytesSent)
    );

    // Narrow counter instance shares all stimulus so the wrap can be observed.
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .CNT_WIDTH(2)) dutWrap (
        .clk(clk), .reset(reset), .txEnable(txEnable), .fifoEmpty(fifoEmpty),
        .fifoRdData(fifoRdData), .fifoRdEn(fifoRdEnW), .txOut(txOutW),
        .txBusy(txBusyW), .bytesSent(bytesSentW)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Advance one clock; the FIFO model serves a pop with data after the edge.
    task automatic cycle();
        logic pop;
        #1;
        pop = fifoRdEn;
        if (pop && (fifoEmpty || lastPop)) badPops++;
        if (pop) popCount++;
        lastPop = pop;
        @(posedge clk);
        #1;
        if (pop && q.size() > 0) fifoRdData = q.pop_front();
        fifoEmpty = (q.size() == 0);
        @(negedge clk);
        #1;
    endtask

    // Starts on the pop cycle; ends on the first IDLE cycle after the frame.
    task automatic checkFrame(input logic [7:0] b, input int dropAt, input int abortAt);
        logic [2:0] e;
        logic       tx;
        for (int k = 0; k < 42; k++) begin
            if (k < 2)       tx = 1'b1;
            else if (k < 6)  tx = 1'b0;
            else if (k < 38) tx = b[(k - 6) / 4];
            else             tx = 1'b1;
            e = (k == 0) ? 3'b101 : {tx, 2'b10};
            chk($sformatf("frame%02h_k%0d", b, k),
                {26'd0, txOut, txBusy, fifoRdEn, txOutW, txBusyW, fifoRdEnW}, {26'd0, e, e});
            if (k == dropAt) txEnable = 1'b0;
            if (k == abortAt) begin
                reset = 1'b0;
                cycle();
                $display("frame %02h aborted by reset at cycle %0d", b, k);
                return;
            end
            cycle();
        end
        $display("frame %02h sent, bytesSent=%0d", b, bytesSent);
    endtask

    initial begin
        logic [7:0] t3 [4];
        logic [7:0] t6 [4];
        t3 = '{8'd1, 8'd20, 8'd30, 8'd40};
        t6 = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset held with a non-empty FIFO
        reset = 1'b0; txEnable = 1'b1; fifoRdData = '0;
        q.push_back(8'h14); fifoEmpty = 1'b0;
        @(negedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_%0d", i),
                {8'd0, txOut, fifoRdEn, txBusy, bytesSent, txOutW, fifoRdEnW, txBusyW, bytesSentW},
                {8'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0});
            cycle();
        end
        chk("reset_no_pop", popCount, 0);
        reset = 1'b1; settle();

        // Single byte 0x14
        checkFrame(8'h14, -1, -1);
        chk("t2_busy", txBusy, 0);
        chk("t2_sent", bytesSent, 1);
        chk("t2_rden_empty", fifoRdEn, 0);
        chk("t2_pops", popCount, 1);

        // Four preloaded bytes back to back
        foreach (t3[i]) q.push_back(t3[i]);
        fifoEmpty = 1'b0; settle();
        foreach (t3[i]) checkFrame(t3[i], -1, -1);
        chk("t3_rden_empty", fifoRdEn, 0);
        chk("t3_sent", bytesSent, 5);
        chk("t3_sent_wrap", bytesSentW, 1);
        chk("t3_pops", popCount, 5);
        repeat (3) cycle();
        chk("t3_idle_rden", fifoRdEn, 0);
        chk("t3_bad_pops", badPops, 0);

        // txEnable dropped mid-frame
        q.push_back(8'hA5); q.push_back(8'h3C);
        fifoEmpty = 1'b0; settle();
        checkFrame(8'hA5, 10, -1);
        chk("t4_busy", txBusy, 0);
        chk("t4_sent", bytesSent, 6);
        chk("t4_rden", fifoRdEn, 0);
        repeat (5) cycle();
        chk("t4_no_pop", popCount, 6);
        chk("t4_idle", txBusy, 0);
        txEnable = 1'b1; settle();
        checkFrame(8'h3C, -1, -1);
        chk("t4_sent2", bytesSent, 7);
        chk("t4_sent2_wrap", bytesSentW, 3);

        // Reset during data bit 3
        q.push_back(8'h5A); q.push_back(8'hC3);
        fifoEmpty = 1'b0; settle();
        checkFrame(8'h5A, -1, 19);
        chk("t5_abort", {12'd0, txOut, txBusy, fifoRdEn, bytesSent}, {12'd0, 1'b1, 1'b0, 1'b0, 16'd0});
        chk("t5_abort_wrap", bytesSentW, 0);
        reset = 1'b1; settle();
        checkFrame(8'hC3, -1, -1);
        chk("t5_sent", bytesSent, 1);

        // Counter wrap on the 2-bit instance after five frames
        foreach (t6[i]) q.push_back(t6[i]);
        fifoEmpty = 1'b0; settle();
        foreach (t6[i]) checkFrame(t6[i], -1, -1);
        chk("t6_sent", bytesSent, 5);
        chk("t6_sent_wrap", bytesSentW, 1);
        chk("t6_bad_pops", badPops, 0);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
